memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 132 +++++++++++++
 tb/tb_memory_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port (instruction/data) arbiter in front of a single RAM
module memory_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, ERR} state_e;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // The watchdog is only 4 bits wide, so the limit is clamped into 1..15.
  localparam int         WLIM   = (MAX_WAIT > 15) ? 15 : ((MAX_WAIT < 1) ? 1 : MAX_WAIT);
  localparam logic [3:0] WLIM_C = 4'(WLIM);

  state_e     state_q, state_d;
  logic [3:0] wdog_q, wdog_d;
  logic       err_q, err_d;

  logic       dreq;
  logic       grant_req;
  logic [3:0] wdog_inc;

  assign dreq     = dREN | dWEN;
  assign wdog_inc = (wdog_q == 4'hF) ? wdog_q : wdog_q + 4'd1;

  // State, watchdog and sticky error flag; reset takes effect without a clock edge.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      wdog_q  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: data beats instruction in IDLE, no preemption once granted.
  always_comb begin
    state_d   = state_q;
    wdog_d    = wdog_q;
    grant_req = 1'b0;
    case (state_q)
      IDLE: begin
        wdog_d = 4'd0;
        if (dreq) begin
          state_d = DATA;
        end else if (iREN) begin
          state_d = INSTR;
        end
      end
      INSTR, DATA: begin
        grant_req = (state_q == INSTR) ? iREN : dreq;
        wdog_d    = wdog_inc;
        if (ramstate == RAM_ACCESS) begin
          state_d = IDLE;
        end else if (ramstate == RAM_ERROR) begin
          state_d = ERR;
        end else if (!grant_req) begin
          state_d = IDLE;
        end else if (wdog_inc >= WLIM_C) begin
          state_d = ERR;
        end
      end
      ERR: begin
        wdog_d  = 4'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q | (state_d == ERR);
  end

  // RAM-side strobes and requester stalls decoded from the current state.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN;
    dwait    = dreq;
    case (state_q)
      INSTR: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ramstate == RAM_ACCESS) begin
          iwait = 1'b0;
        end
      end
      DATA: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = ~dWEN;
        if (ramstate == RAM_ACCESS) begin
          dwait = 1'b0;
        end
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  assign iload = ramload;
  assign dload = ramload;
  assign err   = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - scoreboard bench for memory_arbiter
module tb_memory_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  memory_arbiter dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  typedef struct {
    string       nm;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        iw;
    logic        dw;
    logic        er;
  } exp_t;

  exp_t        chk_q[$];
  logic [31:0] icomp_q[$];
  logic [31:0] dcomp_q[$];
  int          checks   = 0;
  int          failures = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: per-cycle snapshot checks and completion checks, sampled on the falling edge.
  always @(negedge CLK) begin
    if (chk_q.size() > 0) begin
      exp_t e;
      e = chk_q.pop_front();
      checks++;
      if ({ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, err} !==
          {e.ren, e.wen, e.addr, e.store, e.iw, e.dw, e.er}) begin
        failures++;
        $display("FAIL %s: got ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b err=%b, want ren=%b wen=%b addr=%h store=%h iwait=%b dwait=%b err=%b",
                 e.nm, ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, err,
                 e.ren, e.wen, e.addr, e.store, e.iw, e.dw, e.er);
      end
      checks++;
      if (iload !== ramload || dload !== ramload) begin
        failures++;
        $display("FAIL %s_load: got iload=%h dload=%h, want %h", e.nm, iload, dload, ramload);
      end
    end
    if (iREN && !iwait) begin
      checks++;
      if (icomp_q.size() == 0) begin
        failures++;
        $display("FAIL icomp_unexpected: got completion iload=%h, want none", iload);
      end else begin
        logic [31:0] x;
        x = icomp_q.pop_front();
        if (iload !== x) begin
          failures++;
          $display("FAIL icomp: got iload=%h, want %h", iload, x);
        end
      end
    end
    if ((dREN || dWEN) && !dwait) begin
      checks++;
      if (dcomp_q.size() == 0) begin
        failures++;
        $display("FAIL dcomp_unexpected: got completion dload=%h, want none", dload);
      end else begin
        logic [31:0] x;
        x = dcomp_q.pop_front();
        if (dload !== x) begin
          failures++;
          $display("FAIL dcomp: got dload=%h, want %h", dload, x);
        end
      end
    end
  end

  task automatic step(input string nm, input logic ren, input logic wen,
                      input logic [31:0] addr, input logic [31:0] store,
                      input logic iw, input logic dw, input logic er);
    exp_t e;
    e.nm = nm; e.ren = ren; e.wen = wen; e.addr = addr; e.store = store;
    e.iw = iw; e.dw = dw; e.er = er;
    chk_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    @(posedge CLK);
    #1;

    // reset
    step("reset", 0, 0, 32'h0, 32'h0, 0, 0, 0);
    nRST = 1'b1;
    step("idle", 0, 0, 32'h0, 32'h0, 0, 0, 0);

    // fetch: two BUSY cycles then ACCESS
    iREN = 1; iaddr = 32'h100; ramstate = BUSY;
    step("f_idle", 0, 0, 32'h0, 32'h0, 1, 0, 0);
    step("f_busy1", 1, 0, 32'h100, 32'h0, 1, 0, 0);
    step("f_busy2", 1, 0, 32'h100, 32'h0, 1, 0, 0);
    ramstate = ACCESS; ramload = 32'hDEADBEEF;
    icomp_q.push_back(32'hDEADBEEF);
    step("f_access", 1, 0, 32'h100, 32'h0, 0, 0, 0);
    iREN = 0; ramstate = FREE;
    step("f_done", 0, 0, 32'h0, 32'h0, 0, 0, 0);

    // conflict: data write wins, instruction follows
    iREN = 1; iaddr = 32'h104; dWEN = 1; daddr = 32'h200; dstore = 32'h5;
    step("c_idle", 0, 0, 32'h0, 32'h0, 1, 1, 0);
    ramstate = ACCESS; ramload = 32'h11111111;
    dcomp_q.push_back(32'h11111111);
    step("c_data", 0, 1, 32'h200, 32'h5, 1, 0, 0);
    dWEN = 0; ramstate = FREE;
    step("c_idle2", 0, 0, 32'h0, 32'h0, 1, 0, 0);
    ramstate = ACCESS; ramload = 32'hCAFEF00D;
    icomp_q.push_back(32'hCAFEF00D);
    step("c_instr", 1, 0, 32'h104, 32'h0, 0, 0, 0);
    iREN = 0; ramstate = FREE;
    step("c_done", 0, 0, 32'h0, 32'h0, 0, 0, 0);

    // abort: instruction request withdrawn after one BUSY cycle
    iREN = 1; iaddr = 32'h400; ramstate = BUSY;
    step("a_idle", 0, 0, 32'h0, 32'h0, 1, 0, 0);
    step("a_busy", 1, 0, 32'h400, 32'h0, 1, 0, 0);
    iREN = 0;
    step("a_drop", 1, 0, 32'h400, 32'h0, 0, 0, 0);
    step("a_idle2", 0, 0, 32'h0, 32'h0, 0, 0, 0);

    // watchdog: 15 BUSY cycles in DATA, ERR, IDLE, re-grant
    dREN = 1; daddr = 32'h300; dstore = 32'hAA; ramstate = BUSY;
    step("w_idle", 0, 0, 32'h0, 32'h0, 0, 1, 0);
    for (int k = 1; k <= 15; k++) begin
      step($sformatf("w_busy%0d", k), 1, 0, 32'h300, 32'hAA, 0, 1, 0);
    end
    step("w_err", 0, 0, 32'h0, 32'h0, 0, 1, 1);
    step("w_idle2", 0, 0, 32'h0, 32'h0, 0, 1, 1);
    ramstate = ACCESS; ramload = 32'h12345678;
    dcomp_q.push_back(32'h12345678);
    step("w_regrant", 1, 0, 32'h300, 32'hAA, 0, 0, 1);
    dREN = 0; ramstate = FREE;
    step("w_done", 0, 0, 32'h0, 32'h0, 0, 0, 1);

    // asynchronous reset during a data write
    dWEN = 1; daddr = 32'h600; dstore = 32'h99; ramstate = BUSY;
    step("r_idle", 0, 0, 32'h0, 32'h0, 0, 1, 1);
    step("r_data", 0, 1, 32'h600, 32'h99, 0, 1, 1);
    nRST = 0;
    step("r_async", 0, 0, 32'h0, 32'h0, 0, 1, 0);
    nRST = 1;
    step("r_release", 0, 0, 32'h0, 32'h0, 0, 1, 0);
    ramstate = ACCESS; ramload = 32'hA5A5A5A5;
    dcomp_q.push_back(32'hA5A5A5A5);
    step("r_regrant", 0, 1, 32'h600, 32'h99, 0, 0, 0);
    dWEN = 0; ramstate = FREE;
    step("r_done", 0, 0, 32'h0, 32'h0, 0, 0, 0);

    // RAM ERROR status with both dREN and dWEN high (write wins)
    dREN = 1; dWEN = 1; daddr = 32'h500; dstore = 32'h77; ramstate = BUSY;
    step("e_idle", 0, 0, 32'h0, 32'h0, 0, 1, 0);
    ramstate = ERROR;
    step("e_data", 0, 1, 32'h500, 32'h77, 0, 1, 0);
    dREN = 0; dWEN = 0; ramstate = FREE;
    step("e_err", 0, 0, 32'h0, 32'h0, 0, 0, 1);
    step("e_idle2", 0, 0, 32'h0, 32'h0, 0, 0, 1);

    @(posedge CLK);
    #1;
    checks++;
    if (chk_q.size() != 0 || icomp_q.size() != 0 || dcomp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got pending chk=%0d icomp=%0d dcomp=%0d, want 0 0 0",
               chk_q.size(), icomp_q.size(), dcomp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
